// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg
// Shared definitions for the L1 data cache slice: line geometry, the snoop
// opcode that invalidates a line, the miss-handling FSM state type and a
// helper that pulls an 8-byte little-endian word out of a 64-byte line.
package l1_cache_pkg;

  localparam int LINE_BYTES  = 64;
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int OFFSET_BITS = 6;

  localparam logic [3:0] SNOOP_INVALIDATE = 4'hD;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    RESPOND
  } cache_state_e;

  // Shifting right zero-fills, so bytes beyond the end of the line read as zero.
  function automatic logic [63:0] extract_word(input logic [LINE_BITS-1:0]   line,
                                               input logic [OFFSET_BITS-1:0] offset);
    return 64'(line >> {offset, 3'b000});
  endfunction

endpackage

// File: rtl/l1_d_line_store.sv
// l1_d_line_store
// Direct-mapped tag/valid/dirty/data array for the L1 data cache.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   rd_index -> rd_valid/dirty/tag/data  combinational lookup of one set
//   fill_*                          - install a full line (valid, clean)
//   store_*                         - byte-merge up to 8 bytes at an offset, sets dirty
//   inv_*                           - invalidate a set if its tag matches
module l1_d_line_store
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 52
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  rd_index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [LINE_BITS-1:0]   rd_data,
  input  logic                   fill_en,
  input  logic [INDEX_BITS-1:0]  fill_index,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [LINE_BITS-1:0]   fill_data,
  input  logic                   store_en,
  input  logic [INDEX_BITS-1:0]  store_index,
  input  logic [OFFSET_BITS-1:0] store_offset,
  input  logic [3:0]             store_size,
  input  logic [63:0]            store_data,
  input  logic                   inv_en,
  input  logic [INDEX_BITS-1:0]  inv_index,
  input  logic [TAG_BITS-1:0]    inv_tag
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  logic [7:0]            size_mask;
  logic [LINE_BYTES-1:0] byte_mask;
  logic [LINE_BITS-1:0]  bit_mask;
  logic [LINE_BITS-1:0]  shifted_data;
  logic [LINE_BITS-1:0]  merged_line;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  // Store data is LSB-aligned; slide it and a byte-enable mask up to the offset.
  always_comb begin
    size_mask    = 8'((16'd1 << store_size) - 16'd1);
    byte_mask    = LINE_BYTES'(size_mask) << store_offset;
    shifted_data = LINE_BITS'(store_data) << {store_offset, 3'b000};
    bit_mask     = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_mask[b]}};
    end
    merged_line = (data_q[store_index] & ~bit_mask) | (shifted_data & bit_mask);
  end

  // Fill is applied last so it overrides a same-cycle snoop to the same set.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (inv_en && valid_q[inv_index] && (tag_q[inv_index] == inv_tag)) begin
        valid_q[inv_index] <= 1'b0;
        dirty_q[inv_index] <= 1'b0;
      end
      if (store_en) begin
        dirty_q[store_index] <= 1'b1;
      end
      if (fill_en) begin
        valid_q[fill_index] <= 1'b1;
        dirty_q[fill_index] <= 1'b0;
      end
    end
  end

  // Tag and data carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end
    if (store_en) begin
      data_q[store_index] <= merged_line;
    end
  end

endmodule

// File: rtl/l1_d_cache.sv
// l1_d_cache
// Direct-mapped, write-allocate, write-back L1 data cache with 64-byte lines.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   S_R_*                          - load request / 8-byte load data strobe
//   S_W_*                          - store request (1/2/4/8 bytes), ready, completion pulse
//   L2_S_R_*                       - line fill request / fill data from L2
//   L2_S_W_*                       - dirty victim writeback to L2
//   m_axi_ac*                      - bus snoop channel
// Configuration macro: L1D_SNOOP_INV_EN - when defined, a snoop with opcode
// SNOOP_INVALIDATE and matching tag/index drops the line (no writeback);
// when undefined the snoop inputs are ignored.
module l1_d_cache
  import l1_cache_pkg::*;
#(
  parameter int NUM_SETS   = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
  input  logic                  S_R_ADDR_VALID,
  output logic [63:0]           S_R_DATA,
  output logic                  S_R_DATA_VALID,
  input  logic                  S_W_VALID,
  input  logic [ADDR_WIDTH-1:0] S_W_ADDR,
  input  logic [63:0]           S_W_DATA,
  input  logic [3:0]            S_W_SIZE,
  output logic                  S_W_READY,
  output logic                  S_W_COMPLETE,
  output logic [ADDR_WIDTH-1:0] L2_S_R_ADDR,
  output logic                  L2_S_R_ADDR_VALID,
  input  logic [LINE_BITS-1:0]  L2_S_R_DATA,
  input  logic                  L2_S_R_DATA_VALID,
  output logic                  L2_S_W_VALID,
  output logic [ADDR_WIDTH-1:0] L2_S_W_ADDR,
  output logic [LINE_BITS-1:0]  L2_S_W_DATA,
  input  logic                  L2_S_W_READY,
  input  logic                  L2_S_W_COMPLETE,
  input  logic                  m_axi_acvalid,
  input  logic [ADDR_WIDTH-1:0] m_axi_acaddr,
  input  logic [3:0]            m_axi_acsnoop
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

  cache_state_e state, next_state;

  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   req_is_store;
  logic [63:0]            req_wdata;
  logic [3:0]             req_size;

  logic [ADDR_WIDTH-1:0]  lk_addr;
  logic [INDEX_BITS-1:0]  lk_index;
  logic [TAG_BITS-1:0]    lk_tag;
  logic                   rd_valid, rd_dirty, hit;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [LINE_BITS-1:0]   rd_data;

  logic                   load_go, store_go;
  logic                   accept_load, accept_store, hit_load, hit_store;
  logic                   go_wb, go_fill;
  logic                   fill_en, store_en;
  logic [INDEX_BITS-1:0]  st_index;
  logic [OFFSET_BITS-1:0] st_offset;
  logic [63:0]            st_data;
  logic [3:0]             st_size;

  logic                   inv_en;
  logic [INDEX_BITS-1:0]  inv_index;
  logic [TAG_BITS-1:0]    inv_tag;

  assign S_W_READY = (state == IDLE) && !S_R_ADDR_VALID;

  // A load stays asserted through its data pulse; ignoring it during the
  // pulse keeps a hit from being served twice.
  assign load_go  = S_R_ADDR_VALID && !S_R_DATA_VALID;
  assign store_go = S_W_VALID && S_W_READY;

  // Outside IDLE the lookup follows the captured miss address.
  assign lk_addr  = (state != IDLE) ? req_addr : (S_R_ADDR_VALID ? S_R_ADDR : S_W_ADDR);
  assign lk_index = lk_addr[OFFSET_BITS +: INDEX_BITS];
  assign lk_tag   = lk_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign hit      = rd_valid && (rd_tag == lk_tag);

  assign fill_en  = (state == FILL) && L2_S_R_DATA_VALID;
  assign store_en = hit_store || ((state == RESPOND) && req_is_store);

  always_comb begin
    if (state == IDLE) begin
      st_index  = S_W_ADDR[OFFSET_BITS +: INDEX_BITS];
      st_offset = S_W_ADDR[OFFSET_BITS-1:0];
      st_data   = S_W_DATA;
      st_size   = S_W_SIZE;
    end else begin
      st_index  = req_addr[OFFSET_BITS +: INDEX_BITS];
      st_offset = req_addr[OFFSET_BITS-1:0];
      st_data   = req_wdata;
      st_size   = req_size;
    end
  end

`ifdef L1D_SNOOP_INV_EN
  logic unused_snoop;
  assign inv_en       = m_axi_acvalid && (m_axi_acsnoop == SNOOP_INVALIDATE);
  assign inv_index    = m_axi_acaddr[OFFSET_BITS +: INDEX_BITS];
  assign inv_tag      = m_axi_acaddr[ADDR_WIDTH-1 -: TAG_BITS];
  assign unused_snoop = ^m_axi_acaddr[OFFSET_BITS-1:0];
`else
  logic unused_snoop;
  assign inv_en       = 1'b0;
  assign inv_index    = '0;
  assign inv_tag      = '0;
  assign unused_snoop = ^{m_axi_acvalid, m_axi_acaddr, m_axi_acsnoop};
`endif

  l1_d_line_store #(
    .NUM_SETS   (NUM_SETS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_line_store (
    .clk          (clk),
    .reset        (reset),
    .rd_index     (lk_index),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .fill_en      (fill_en),
    .fill_index   (lk_index),
    .fill_tag     (lk_tag),
    .fill_data    (L2_S_R_DATA),
    .store_en     (store_en),
    .store_index  (st_index),
    .store_offset (st_offset),
    .store_size   (st_size),
    .store_data   (st_data),
    .inv_en       (inv_en),
    .inv_index    (inv_index),
    .inv_tag      (inv_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Loads win over stores in IDLE because S_W_READY already drops while a
  // load is pending, so load_go and store_go are never both set.
  always_comb begin
    next_state   = state;
    accept_load  = 1'b0;
    accept_store = 1'b0;
    hit_load     = 1'b0;
    hit_store    = 1'b0;
    go_wb        = 1'b0;
    go_fill      = 1'b0;
    case (state)
      IDLE: begin
        if (load_go || store_go) begin
          accept_load  = load_go;
          accept_store = store_go;
          if (hit) begin
            hit_load  = load_go;
            hit_store = store_go;
          end else if (rd_valid && rd_dirty) begin
            go_wb      = 1'b1;
            next_state = WRITEBACK;
          end else begin
            go_fill    = 1'b1;
            next_state = FILL;
          end
        end
      end
      WRITEBACK: begin
        if (L2_S_W_VALID && L2_S_W_COMPLETE) begin
          go_fill    = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        if (L2_S_R_DATA_VALID) next_state = RESPOND;
      end
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, response strobes and L2 handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr          <= '0;
      req_is_store      <= 1'b0;
      req_wdata         <= '0;
      req_size          <= '0;
      S_R_DATA          <= '0;
      S_R_DATA_VALID    <= 1'b0;
      S_W_COMPLETE      <= 1'b0;
      L2_S_R_ADDR       <= '0;
      L2_S_R_ADDR_VALID <= 1'b0;
      L2_S_W_VALID      <= 1'b0;
      L2_S_W_ADDR       <= '0;
      L2_S_W_DATA       <= '0;
    end else begin
      S_R_DATA_VALID <= 1'b0;
      S_W_COMPLETE   <= 1'b0;
      if (accept_load || accept_store) begin
        req_addr     <= lk_addr;
        req_is_store <= accept_store;
        req_wdata    <= S_W_DATA;
        req_size     <= S_W_SIZE;
      end
      if (hit_load) begin
        S_R_DATA_VALID <= 1'b1;
        S_R_DATA       <= extract_word(rd_data, lk_addr[OFFSET_BITS-1:0]);
      end
      if (hit_store) S_W_COMPLETE <= 1'b1;
      if (go_wb) begin
        L2_S_W_ADDR <= {rd_tag, lk_index, {OFFSET_BITS{1'b0}}};
        L2_S_W_DATA <= rd_data;
      end
      if (state == WRITEBACK) begin
        if (!L2_S_W_VALID && L2_S_W_READY)         L2_S_W_VALID <= 1'b1;
        else if (L2_S_W_VALID && L2_S_W_COMPLETE)  L2_S_W_VALID <= 1'b0;
      end
      if (go_fill) begin
        L2_S_R_ADDR       <= {lk_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        L2_S_R_ADDR_VALID <= 1'b1;
      end
      // Load data comes straight from the fill beat so it is ready in RESPOND.
      if (fill_en) begin
        L2_S_R_ADDR_VALID <= 1'b0;
        if (!req_is_store) begin
          S_R_DATA_VALID <= 1'b1;
          S_R_DATA       <= extract_word(L2_S_R_DATA, req_addr[OFFSET_BITS-1:0]);
        end
      end
      if ((state == RESPOND) && req_is_store) S_W_COMPLETE <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_d_cache.sv
// tb_l1_d_cache
// Directed self-checking bench for l1_d_cache with a small L2 responder model.
module tb_l1_d_cache;

  localparam int NUM_SETS = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  S_R_ADDR;
  logic         S_R_ADDR_VALID;
  logic [63:0]  S_R_DATA;
  logic         S_R_DATA_VALID;
  logic         S_W_VALID;
  logic [63:0]  S_W_ADDR;
  logic [63:0]  S_W_DATA;
  logic [3:0]   S_W_SIZE;
  logic         S_W_READY;
  logic         S_W_COMPLETE;
  logic [63:0]  L2_S_R_ADDR;
  logic         L2_S_R_ADDR_VALID;
  logic [511:0] L2_S_R_DATA;
  logic         L2_S_R_DATA_VALID;
  logic         L2_S_W_VALID;
  logic [63:0]  L2_S_W_ADDR;
  logic [511:0] L2_S_W_DATA;
  logic         L2_S_W_READY;
  logic         L2_S_W_COMPLETE;
  logic         m_axi_acvalid;
  logic [63:0]  m_axi_acaddr;
  logic [3:0]   m_axi_acsnoop;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [511:0] l2_mem [logic [63:0]];

  int           r_lat, r_pulses, w_lat, w_pulses, l2r_count, l2r_hold, wb_count;
  logic [63:0]  r_data, l2r_addr, wb_addr;
  logic [511:0] wb_data;
  logic         ready_first;
  bit           addr_changed;

  logic [511:0] exp_line;
  int           exp_snoop_reads;
  int           stray_pulses;
  bit           saw_fill_req;

  always #5 clk = ~clk;

  l1_d_cache #(.NUM_SETS(NUM_SETS), .ADDR_WIDTH(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .S_R_ADDR          (S_R_ADDR),
    .S_R_ADDR_VALID    (S_R_ADDR_VALID),
    .S_R_DATA          (S_R_DATA),
    .S_R_DATA_VALID    (S_R_DATA_VALID),
    .S_W_VALID         (S_W_VALID),
    .S_W_ADDR          (S_W_ADDR),
    .S_W_DATA          (S_W_DATA),
    .S_W_SIZE          (S_W_SIZE),
    .S_W_READY         (S_W_READY),
    .S_W_COMPLETE      (S_W_COMPLETE),
    .L2_S_R_ADDR       (L2_S_R_ADDR),
    .L2_S_R_ADDR_VALID (L2_S_R_ADDR_VALID),
    .L2_S_R_DATA       (L2_S_R_DATA),
    .L2_S_R_DATA_VALID (L2_S_R_DATA_VALID),
    .L2_S_W_VALID      (L2_S_W_VALID),
    .L2_S_W_ADDR       (L2_S_W_ADDR),
    .L2_S_W_DATA       (L2_S_W_DATA),
    .L2_S_W_READY      (L2_S_W_READY),
    .L2_S_W_COMPLETE   (L2_S_W_COMPLETE),
    .m_axi_acvalid     (m_axi_acvalid),
    .m_axi_acaddr      (m_axi_acaddr),
    .m_axi_acsnoop     (m_axi_acsnoop)
  );

  function automatic logic [511:0] make_line(input logic [7:0] base);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[i*8 +: 8] = 8'(base + 8'(i));
    return l;
  endfunction

  function automatic logic [511:0] l2_read(input logic [63:0] addr);
    if (l2_mem.exists(addr)) return l2_mem[addr];
    return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issues a load and/or store, services the L2 ports, and records what happened.
  task automatic applyStimulus(input bit do_ld, input logic [63:0] ld_addr,
                               input bit do_st, input logic [63:0] st_addr,
                               input logic [63:0] st_data, input logic [3:0] st_size);
    bit ld_done, st_done, rdv_next, wcmp_next, drop_st, prev_rav;
    int rav_cnt, wv_cnt, post;
    r_lat = -1; r_pulses = 0; w_lat = -1; w_pulses = 0;
    l2r_count = 0; l2r_hold = 0; wb_count = 0; addr_changed = 0;
    r_data = '0; l2r_addr = '0; wb_addr = '0; wb_data = '0; ready_first = 1'b0;
    prev_rav = 0; rav_cnt = 0; wv_cnt = 0; post = 0;
    @(posedge clk); #1;
    S_R_ADDR = ld_addr; S_R_ADDR_VALID = do_ld;
    S_W_ADDR = st_addr; S_W_DATA = st_data; S_W_SIZE = st_size; S_W_VALID = do_st;
    ld_done = !do_ld; st_done = !do_st;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) ready_first = S_W_READY;
      if (S_R_DATA_VALID) begin
        r_pulses++;
        if (!ld_done) begin ld_done = 1; r_lat = i - 1; r_data = S_R_DATA; end
      end
      if (S_W_COMPLETE) begin
        w_pulses++;
        if (!st_done) begin st_done = 1; w_lat = i - 1; end
      end
      drop_st = S_W_VALID && S_W_READY;
      if (L2_S_R_ADDR_VALID) begin
        if (!prev_rav) begin l2r_count++; l2r_addr = L2_S_R_ADDR; rav_cnt = 0; end
        if (L2_S_R_ADDR != l2r_addr) addr_changed = 1;
        rav_cnt++;
        l2r_hold = rav_cnt;
      end
      prev_rav = L2_S_R_ADDR_VALID;
      rdv_next = L2_S_R_ADDR_VALID && (rav_cnt == 2);
      if (L2_S_W_VALID) begin
        wv_cnt++;
        if (wv_cnt == 1) begin wb_count++; wb_addr = L2_S_W_ADDR; wb_data = L2_S_W_DATA; end
      end else begin
        wv_cnt = 0;
      end
      wcmp_next = L2_S_W_VALID && (wv_cnt == 1);
      if (ld_done && st_done) post++;
      if (post >= 3) break;
      @(posedge clk); #1;
      if (S_R_ADDR_VALID && ld_done) S_R_ADDR_VALID = 1'b0;
      if (drop_st) S_W_VALID = 1'b0;
      L2_S_R_DATA_VALID = rdv_next;
      L2_S_R_DATA       = rdv_next ? l2_read(l2r_addr) : '0;
      L2_S_W_COMPLETE   = wcmp_next;
      if (wcmp_next) l2_mem[wb_addr] = wb_data;
    end
    S_R_ADDR_VALID = 1'b0; S_W_VALID = 1'b0;
    L2_S_R_DATA_VALID = 1'b0; L2_S_W_COMPLETE = 1'b0;
    checkOutput("request_completed", {ld_done, st_done}, 2'b11);
    checkOutput("l2_addr_stable", addr_changed, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    S_R_ADDR = '0; S_R_ADDR_VALID = 0; S_W_VALID = 0; S_W_ADDR = '0; S_W_DATA = '0; S_W_SIZE = '0;
    L2_S_R_DATA = '0; L2_S_R_DATA_VALID = 0; L2_S_W_READY = 1'b1; L2_S_W_COMPLETE = 0;
    m_axi_acvalid = 0; m_axi_acaddr = '0; m_axi_acsnoop = '0;
    l2_mem[64'h1000] = make_line(8'h00);
    l2_mem[64'h2000] = make_line(8'h80);
    l2_mem[64'h1040] = make_line(8'h40);

    $display("[TB] reset values");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_r_data_valid", S_R_DATA_VALID, 1'b0);
    checkOutput("rst_w_complete", S_W_COMPLETE, 1'b0);
    checkOutput("rst_l2_r_valid", L2_S_R_ADDR_VALID, 1'b0);
    checkOutput("rst_l2_w_valid", L2_S_W_VALID, 1'b0);
    checkOutput("rst_r_data", S_R_DATA, 64'h0);
    checkOutput("rst_l2_r_addr", L2_S_R_ADDR, 64'h0);
    checkOutput("rst_l2_w_addr", L2_S_W_ADDR, 64'h0);
    checkOutput("rst_l2_w_data", L2_S_W_DATA, 512'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_w_ready", S_W_READY, 1'b1);

    $display("[TB] cold load 0x1008");
    applyStimulus(1, 64'h1008, 0, '0, '0, '0);
    checkOutput("cold_l2_reads", l2r_count, 1);
    checkOutput("cold_l2_addr", l2r_addr, 64'h1000);
    checkOutput("cold_l2_hold", l2r_hold, 3);
    checkOutput("cold_data", r_data, 64'h0F0E0D0C0B0A0908);
    checkOutput("cold_pulses", r_pulses, 1);
    checkOutput("cold_wb", wb_count, 0);

    $display("[TB] repeat load 0x1008");
    applyStimulus(1, 64'h1008, 0, '0, '0, '0);
    checkOutput("hit_latency", r_lat, 1);
    checkOutput("hit_l2_reads", l2r_count, 0);
    checkOutput("hit_data", r_data, 64'h0F0E0D0C0B0A0908);
    checkOutput("hit_pulses", r_pulses, 1);

    $display("[TB] store hit then load");
    applyStimulus(0, '0, 1, 64'h1010, 64'hDEADBEEF, 4'd4);
    checkOutput("st_hit_latency", w_lat, 1);
    checkOutput("st_hit_pulses", w_pulses, 1);
    checkOutput("st_hit_l2_reads", l2r_count, 0);
    applyStimulus(1, 64'h1010, 0, '0, '0, '0);
    checkOutput("ld_after_st_data", r_data, 64'h17161514DEADBEEF);
    checkOutput("ld_after_st_l2_reads", l2r_count, 0);

    $display("[TB] conflict load with dirty victim");
    applyStimulus(1, 64'h1000 + NUM_SETS * 64, 0, '0, '0, '0);
    exp_line = make_line(8'h00);
    exp_line[16*8 +: 32] = 32'hDEADBEEF;
    checkOutput("wb_count", wb_count, 1);
    checkOutput("wb_addr", wb_addr, 64'h1000);
    checkOutput("wb_data", wb_data, exp_line);
    checkOutput("conf_l2_addr", l2r_addr, 64'h2000);
    checkOutput("conf_data", r_data, 64'h8786858483828180);
    checkOutput("conf_pulses", r_pulses, 1);

    $display("[TB] store miss, write-allocate");
    applyStimulus(0, '0, 1, 64'h1002, 64'hA5B6, 4'd2);
    checkOutput("st_miss_wb", wb_count, 0);
    checkOutput("st_miss_l2_addr", l2r_addr, 64'h1000);
    checkOutput("st_miss_pulses", w_pulses, 1);
    checkOutput("st_miss_no_load", r_pulses, 0);
    applyStimulus(1, 64'h1000, 0, '0, '0, '0);
    checkOutput("st_miss_merge", r_data, 64'h07060504A5B60100);
    checkOutput("st_miss_hit", l2r_count, 0);

    $display("[TB] load near line end");
    applyStimulus(1, 64'h103C, 0, '0, '0, '0);
    checkOutput("line_end_data", r_data, 64'h000000003F3E3D3C);

    $display("[TB] snoop");
    applyStimulus(1, 64'h1040, 0, '0, '0, '0);
    checkOutput("snoop_fill_data", r_data, 64'h4746454443424140);
    @(posedge clk); #1;
    m_axi_acvalid = 1'b1; m_axi_acaddr = 64'h1040; m_axi_acsnoop = 4'h0;
    @(posedge clk); #1 m_axi_acvalid = 1'b0;
    applyStimulus(1, 64'h1040, 0, '0, '0, '0);
    checkOutput("snoop_other_op_hit", l2r_count, 0);
    @(posedge clk); #1;
    m_axi_acvalid = 1'b1; m_axi_acaddr = 64'h1040; m_axi_acsnoop = 4'hD;
    @(posedge clk); #1 m_axi_acvalid = 1'b0;
    applyStimulus(1, 64'h1040, 0, '0, '0, '0);
`ifdef L1D_SNOOP_INV_EN
    exp_snoop_reads = 1;
`else
    exp_snoop_reads = 0;
`endif
    checkOutput("snoop_inv_l2_reads", l2r_count, exp_snoop_reads);
    checkOutput("snoop_inv_data", r_data, 64'h4746454443424140);

    $display("[TB] simultaneous load and store");
    applyStimulus(1, 64'h1040, 1, 64'h1048, 64'h77, 4'd1);
    checkOutput("simul_ready_low", ready_first, 1'b0);
    checkOutput("simul_load_lat", r_lat, 1);
    checkOutput("simul_store_lat", w_lat, 3);
    applyStimulus(1, 64'h1048, 0, '0, '0, '0);
    checkOutput("simul_store_data", r_data, 64'h4F4E4D4C4B4A4977);

    $display("[TB] reset during fill");
    @(posedge clk); #1;
    S_R_ADDR = 64'h1080; S_R_ADDR_VALID = 1'b1;
    saw_fill_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (L2_S_R_ADDR_VALID) begin saw_fill_req = 1; break; end
    end
    checkOutput("rst_fill_reached", saw_fill_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; S_R_ADDR_VALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_fill_l2_valid", L2_S_R_ADDR_VALID, 1'b0);
    checkOutput("rst_fill_l2_addr", L2_S_R_ADDR, 64'h0);
    checkOutput("rst_fill_r_data", S_R_DATA, 64'h0);
    @(posedge clk); #1 reset = 1'b0;
    stray_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (S_R_DATA_VALID || L2_S_R_ADDR_VALID) stray_pulses++;
    end
    checkOutput("rst_fill_no_pulse", stray_pulses, 0);
    applyStimulus(1, 64'h1008, 0, '0, '0, '0);
    checkOutput("rst_fill_reload_miss", l2r_count, 1);
    checkOutput("rst_fill_reload_data", r_data, 64'h0F0E0D0C0B0A0908);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
